// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, stage flag bundle and helpers
package vga_pkg;

  localparam int VGA_HD = 640;
  localparam int VGA_HF = 16;
  localparam int VGA_HS = 96;
  localparam int VGA_HB = 48;
  localparam int VGA_VD = 480;
  localparam int VGA_VF = 10;
  localparam int VGA_VS = 2;
  localparam int VGA_VB = 33;

  // 800x600 at 40 MHz pixel clock
  localparam int SVGA_HD = 800;
  localparam int SVGA_HF = 40;
  localparam int SVGA_HS = 128;
  localparam int SVGA_HB = 88;
  localparam int SVGA_VD = 600;
  localparam int SVGA_VF = 1;
  localparam int SVGA_VS = 4;
  localparam int SVGA_VB = 23;

  typedef struct packed {
    logic hs;
    logic vs;
    logic valid;
    logic ls;
    logic fs;
  } vga_flags_t;

  function automatic int vga_total(input int d, input int f, input int s, input int b);
    return d + f + s + b;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - bundle of one timing stage: syncs, valid, coordinates, markers
interface vga_timing_gen_if #(
  parameter int CW = 11
);
  logic          hsync;
  logic          vsync;
  logic          valid;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          line_start;
  logic          frame_start;

  modport master (output hsync, vsync, valid, h_cnt, v_cnt, line_start, frame_start);
  modport slave  (input  hsync, vsync, valid, h_cnt, v_cnt, line_start, frame_start);
endinterface

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - fixed-depth register pipeline with asynchronous reset to a given idle word
module vga_delay_line #(
  parameter int             W       = 1,
  parameter int             DEPTH   = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] pipe [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= RST_VAL;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen_core.sv
// rtl/vga_timing_gen_core.sv - raw h/v position counters and stage-0 decode
module vga_timing_gen_core
  import vga_pkg::*;
#(
  parameter int HD   = VGA_HD,
  parameter int HF   = VGA_HF,
  parameter int HS   = VGA_HS,
  parameter int HB   = VGA_HB,
  parameter int VD   = VGA_VD,
  parameter int VF   = VGA_VF,
  parameter int VS   = VGA_VS,
  parameter int VB   = VGA_VB,
  parameter bit HPOL = 1'b0,
  parameter bit VPOL = 1'b0,
  parameter int CW   = 11
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              en,
  vga_timing_gen_if.master  s0
);

  localparam int HT = vga_total(HD, HF, HS, HB);
  localparam int VT = vga_total(VD, VF, VS, VB);

  logic [CW-1:0] h_pos;
  logic [CW-1:0] v_pos;
  logic          moved;
  logic          hs0, vs0, valid0, ls0;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      h_pos <= '0;
      v_pos <= '0;
      moved <= 1'b1;
    end else begin
      moved <= en;
      if (en) begin
        if (int'(h_pos) == HT - 1) begin
          h_pos <= '0;
          v_pos <= (int'(v_pos) == VT - 1) ? '0 : v_pos + 1'b1;
        end else begin
          h_pos <= h_pos + 1'b1;
        end
      end
    end
  end

  assign hs0    = (int'(h_pos) >= HD + HF) && (int'(h_pos) < HD + HF + HS);
  assign vs0    = (int'(v_pos) >= VD + VF) && (int'(v_pos) < VD + VF + VS);
  assign valid0 = (int'(h_pos) < HD) && (int'(v_pos) < VD);
  // Markers fire only on the first cycle at position 0, not while parked there with en low
  assign ls0    = (h_pos == '0) && moved;

  assign s0.hsync       = hs0 ? HPOL : ~HPOL;
  assign s0.vsync       = vs0 ? VPOL : ~VPOL;
  assign s0.valid       = valid0;
  assign s0.h_cnt       = valid0 ? h_pos : '0;
  assign s0.v_cnt       = valid0 ? v_pos : '0;
  assign s0.line_start  = ls0;
  assign s0.frame_start = ls0 && (v_pos == '0);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA timing generator top; VGA_FRAME_CNT_EN adds a 16-bit frame counter
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int HD   = VGA_HD,
  parameter int HF   = VGA_HF,
  parameter int HS   = VGA_HS,
  parameter int HB   = VGA_HB,
  parameter int VD   = VGA_VD,
  parameter int VF   = VGA_VF,
  parameter int VS   = VGA_VS,
  parameter int VB   = VGA_VB,
  parameter bit HPOL = 1'b0,
  parameter bit VPOL = 1'b0,
  parameter int CW   = 11,
  parameter int LAT  = 2
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          valid,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int W = $bits(vga_flags_t) + 2 * CW;
  localparam vga_flags_t IDLE_FLAGS = '{hs: ~HPOL, vs: ~VPOL, valid: 1'b0, ls: 1'b0, fs: 1'b0};
  localparam logic [W-1:0] IDLE_WORD = {IDLE_FLAGS, {(2*CW){1'b0}}};

  vga_timing_gen_if #(.CW(CW)) s0 ();

  vga_flags_t    f0, fq;
  logic [W-1:0]  d_in, d_out;

  vga_timing_gen_core #(
    .HD(HD), .HF(HF), .HS(HS), .HB(HB),
    .VD(VD), .VF(VF), .VS(VS), .VB(VB),
    .HPOL(HPOL), .VPOL(VPOL), .CW(CW)
  ) u_core (
    .pclk  (pclk),
    .reset (reset),
    .en    (en),
    .s0    (s0)
  );

  assign f0   = '{hs: s0.hsync, vs: s0.vsync, valid: s0.valid, ls: s0.line_start, fs: s0.frame_start};
  assign d_in = {f0, s0.h_cnt, s0.v_cnt};

  // Whole stage travels as one word so every output stays aligned; it runs even when en is low
  vga_delay_line #(
    .W(W), .DEPTH(LAT), .RST_VAL(IDLE_WORD)
  ) u_delay (
    .clk  (pclk),
    .rst  (reset),
    .din  (d_in),
    .dout (d_out)
  );

  assign fq          = d_out[W-1 -: $bits(vga_flags_t)];
  assign h_cnt       = d_out[2*CW-1 -: CW];
  assign v_cnt       = d_out[CW-1:0];
  assign hsync       = fq.hs;
  assign vsync       = fq.vs;
  assign valid       = fq.valid;
  assign line_start  = fq.ls;
  assign frame_start = fq.fs;

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) frame_cnt <= '0;
    else if (frame_start) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench: 640x480 defaults, 800x600 with HPOL=1, tiny frame config
module tb_vga_timing_gen;
  import vga_pkg::*;

  logic pclk = 1'b0;
  logic reset;
  logic en;
  int   vecs = 0;
  int   errs = 0;

  always #5 pclk = ~pclk;

  vga_timing_gen_if #(.CW(11)) mon ();

  logic        b_hs, b_vs, b_valid, b_ls, b_fs;
  logic [10:0] b_h, b_v;
  logic        c_hs, c_vs, c_valid, c_ls, c_fs;
  logic [4:0]  c_h, c_v;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] a_fc, b_fc, c_fc;
`endif

  vga_timing_gen u_a (
    .pclk(pclk), .reset(reset), .en(en),
    .hsync(mon.hsync), .vsync(mon.vsync), .valid(mon.valid),
    .h_cnt(mon.h_cnt), .v_cnt(mon.v_cnt),
    .line_start(mon.line_start), .frame_start(mon.frame_start)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(a_fc)
`endif
  );

  vga_timing_gen #(
    .HD(SVGA_HD), .HF(SVGA_HF), .HS(SVGA_HS), .HB(SVGA_HB),
    .VD(SVGA_VD), .VF(SVGA_VF), .VS(SVGA_VS), .VB(SVGA_VB),
    .HPOL(1'b1), .VPOL(1'b0), .CW(11), .LAT(2)
  ) u_b (
    .pclk(pclk), .reset(reset), .en(en),
    .hsync(b_hs), .vsync(b_vs), .valid(b_valid), .h_cnt(b_h), .v_cnt(b_v),
    .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(b_fc)
`endif
  );

  // HT=16, VT=8 -> 128-cycle frame, three-stage pipeline
  vga_timing_gen #(
    .HD(8), .HF(2), .HS(3), .HB(3),
    .VD(4), .VF(1), .VS(2), .VB(1),
    .HPOL(1'b0), .VPOL(1'b1), .CW(5), .LAT(3)
  ) u_c (
    .pclk(pclk), .reset(reset), .en(en),
    .hsync(c_hs), .vsync(c_vs), .valid(c_valid), .h_cnt(c_h), .v_cnt(c_v),
    .line_start(c_ls), .frame_start(c_fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(c_fc)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge pclk);
  endtask

  initial begin
    int a_hs_low = 0, a_fall = -1, a_rise = -1, a_ls_last = -1, a_ls_n = 0, a_fs_n = 0;
    int b_hs_hi = 0, b_ls_last = -1, b_ls_n = 0;
    int c_fs_last = -1, c_fs_n = 0, c_vs_hi = 0;
    int ls_hold = 0;

    reset = 1'b1;
    en    = 1'b0;
    repeat (3) tick();
    chk("rst_a_hsync", mon.hsync, 1);
    chk("rst_a_vsync", mon.vsync, 1);
    chk("rst_a_valid", mon.valid, 0);
    chk("rst_a_hcnt", mon.h_cnt, 0);
    chk("rst_a_vcnt", mon.v_cnt, 0);
    chk("rst_a_ls", mon.line_start, 0);
    chk("rst_a_fs", mon.frame_start, 0);
    chk("rst_b_hsync", b_hs, 0);
    chk("rst_c_vsync", c_vs, 0);

    reset = 1'b0;
    en    = 1'b1;
    for (int k = 1; k <= 1700; k++) begin
      tick();
      if (k == 1) chk("a_fs_t1", mon.frame_start, 0);
      if (k == 2) begin
        chk("a_fs_t2", mon.frame_start, 1);
        chk("a_ls_t2", mon.line_start, 1);
        chk("a_valid_t2", mon.valid, 1);
        chk("a_hcnt_t2", mon.h_cnt, 0);
        chk("a_vcnt_t2", mon.v_cnt, 0);
        chk("b_fs_t2", b_fs, 1);
        chk("c_fs_t2", c_fs, 0);
      end
      if (k == 3) chk("c_fs_t3", c_fs, 1);
      if (k == 641) begin
        chk("a_valid_t641", mon.valid, 1);
        chk("a_hcnt_t641", mon.h_cnt, 639);
      end
      if (k == 642) begin
        chk("a_valid_t642", mon.valid, 0);
        chk("a_hcnt_t642", mon.h_cnt, 0);
      end
      if (k == 802) begin
        chk("a_vcnt_t802", mon.v_cnt, 1);
        chk("a_hcnt_t802", mon.h_cnt, 0);
      end
      if (k >= 2 && k <= 801 && mon.hsync == 1'b0) a_hs_low++;
      if (a_fall < 0 && mon.hsync == 1'b0) a_fall = k;
      if (a_fall >= 0 && a_rise < 0 && mon.hsync == 1'b1) a_rise = k;
      if (mon.line_start) begin
        if (a_ls_last >= 0) chk("a_ls_period", k - a_ls_last, 800);
        a_ls_last = k;
        a_ls_n++;
      end
      if (mon.frame_start) a_fs_n++;
      if (k >= 2 && k <= 1057 && b_hs == 1'b1) b_hs_hi++;
      if (b_ls) begin
        if (b_ls_last >= 0) chk("b_ls_period", k - b_ls_last, 1056);
        b_ls_last = k;
        b_ls_n++;
      end
      if (k >= 3 && k <= 130 && c_vs == 1'b1) c_vs_hi++;
      if (c_fs) begin
        if (c_fs_last >= 0) chk("c_fs_period", k - c_fs_last, 128);
        c_fs_last = k;
        c_fs_n++;
`ifdef VGA_FRAME_CNT_EN
        if (c_fs_n == 4) chk("c_frame_cnt_4th", c_fc, 3);
`endif
      end
    end
    chk("a_hs_low_cycles", a_hs_low, 96);
    chk("a_hs_fall_tick", a_fall, 658);
    chk("a_hs_rise_tick", a_rise, 754);
    chk("a_ls_count", a_ls_n, 3);
    chk("a_fs_count", a_fs_n, 1);
    chk("b_hs_high_cycles", b_hs_hi, 128);
    chk("b_ls_count", b_ls_n, 2);
    chk("c_vs_active_cycles", c_vs_hi, 32);
    chk("c_fs_count", c_fs_n, 14);

    // h_pos is 100 on line 2 here; freeze the counters for 50 cycles
    chk("a_hcnt_pre_hold", mon.h_cnt, 98);
    chk("a_vcnt_pre_hold", mon.v_cnt, 2);
    en = 1'b0;
    for (int j = 1; j <= 50; j++) begin
      tick();
      if (mon.line_start) ls_hold++;
      if (j >= 2) chk("a_hcnt_hold", mon.h_cnt, 100);
    end
    chk("a_ls_during_hold", ls_hold, 0);
    en = 1'b1;
    tick();
    chk("a_hcnt_resume1", mon.h_cnt, 100);
    tick();
    chk("a_hcnt_resume2", mon.h_cnt, 100);
    tick();
    chk("a_hcnt_resume3", mon.h_cnt, 101);
    chk("a_valid_pre_rst", mon.valid, 1);

    reset = 1'b1;
    #1;
    chk("arst_a_valid", mon.valid, 0);
    chk("arst_a_hcnt", mon.h_cnt, 0);
    chk("arst_a_vcnt", mon.v_cnt, 0);
    chk("arst_a_hsync", mon.hsync, 1);
    chk("arst_b_hsync", b_hs, 0);
    chk("arst_c_vsync", c_vs, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rel_a_fs_t1", mon.frame_start, 0);
    tick();
    chk("rel_a_fs_t2", mon.frame_start, 1);
    chk("rel_a_hcnt_t2", mon.h_cnt, 0);
    chk("rel_a_vcnt_t2", mon.v_cnt, 0);
    chk("rel_c_fs_t2", c_fs, 0);
    tick();
    chk("rel_a_fs_t3", mon.frame_start, 0);
    chk("rel_c_fs_t3", c_fs, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
